// File: rtl/uart_link_if.sv
// Handshake bundle for uart_link: TX word hand-off and RX FIFO read side.
// The controller uses the master modport; the transceiver uses the slave modport.
interface uart_link_if #(
   parameter int DATA_BITS     = 8,
   parameter int RX_FIFO_DEPTH = 4
);
   logic [DATA_BITS-1:0]             tx_data;
   logic                             tx_valid;
   logic                             tx_ready;
   logic                             tx_done;
   logic [DATA_BITS-1:0]             rx_data;
   logic                             rx_valid;
   logic                             rx_ready;
   logic [$clog2(RX_FIFO_DEPTH):0]   rx_count;

   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, tx_done, rx_data, rx_valid, rx_count
   );

   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, tx_done, rx_data, rx_valid, rx_count
   );
endinterface

// File: rtl/uart_link.sv
// Parametrised UART transceiver: TX serialiser, RX deserialiser with false-start
// rejection, first-word fall-through RX FIFO and sticky error flags.
module uart_link #(
   parameter int CLKS_PER_BIT  = 868,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int RX_FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   uart_link_if.slave   bus,
   output logic         tx,
   input  logic         rx,
   output logic         parity_err,
   output logic         frame_err,
   output logic         overrun,
   input  logic         err_clr
);
   localparam int CW   = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
   localparam int BW   = $clog2(DATA_BITS + 1);
   localparam int AW   = $clog2(RX_FIFO_DEPTH);
   localparam int NW   = AW + 1;
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic [NW-1:0] FULL_CNT = NW'(RX_FIFO_DEPTH);
   localparam logic PAR_EN  = (PARITY != 0);
   localparam logic PAR_ODD = (PARITY == 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

   state_e               tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
   logic                 tx_par_q, tx_par_d, rx_par_q, rx_par_d;
   logic                 tx_q, tx_d, tx_ready_q, tx_ready_d, tx_done_q, tx_done_d;
   logic                 rx_s1_q, rx_s2_q, rx_prev_q, rx_push_q, rx_push_d;
   logic                 parity_err_q, parity_err_d, frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d, rx_valid_q, rx_valid_d;
   logic [NW-1:0]        rx_count_q, rx_count_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_BITS-1:0] mem_q [RX_FIFO_DEPTH];
   logic [DATA_BITS-1:0] mem_d [RX_FIFO_DEPTH];
   logic                 par_bad, pop, push_ok;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_d       = tx_q;
      tx_ready_d = tx_ready_q;
      tx_done_d  = 1'b0;
      case (tx_state_q)
         S_IDLE: if (bus.tx_valid && tx_ready_q) begin
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_shift_d = bus.tx_data;
            tx_par_d   = (^bus.tx_data) ^ PAR_ODD;
            tx_d       = 1'b0;
            tx_ready_d = 1'b0;
         end
         S_START: if (tx_cnt_q == BIT_END) begin
            tx_state_d = S_DATA;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
         end else tx_cnt_d = tx_cnt_q + CW'(1);
         S_DATA: if (tx_cnt_q == BIT_END) begin
            tx_cnt_d = '0;
            if (tx_bit_q == LAST_BIT) begin
               tx_state_d = PAR_EN ? S_PARITY : S_STOP;
               tx_d       = PAR_EN ? tx_par_q : 1'b1;
            end else begin
               tx_bit_d   = tx_bit_q + BW'(1);
               tx_d       = tx_shift_q[0];
               tx_shift_d = tx_shift_q >> 1;
            end
         end else tx_cnt_d = tx_cnt_q + CW'(1);
         S_PARITY: if (tx_cnt_q == BIT_END) begin
            tx_state_d = S_STOP;
            tx_cnt_d   = '0;
            tx_d       = 1'b1;
         end else tx_cnt_d = tx_cnt_q + CW'(1);
         S_STOP: if (tx_cnt_q == STOP_END) begin
            tx_state_d = S_IDLE;
            tx_ready_d = 1'b1;
            tx_done_d  = 1'b1;
         end else tx_cnt_d = tx_cnt_q + CW'(1);
         default: tx_state_d = S_IDLE;
      endcase
   end

   // All RX sampling is relative to the start-bit centre, so later samples land mid-bit.
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_par_d     = rx_par_q;
      rx_push_d    = 1'b0;
      parity_err_d = parity_err_q & ~err_clr;
      frame_err_d  = frame_err_q & ~err_clr;
      par_bad      = PAR_EN && (((^rx_shift_q) ^ PAR_ODD) != rx_par_q);
      case (rx_state_q)
         S_IDLE: if (rx_prev_q && !rx_s2_q) begin
            rx_state_d = S_START;
            rx_cnt_d   = '0;
         end
         S_START: if (rx_cnt_q == HALF_END) begin
            rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
         end else rx_cnt_d = rx_cnt_q + CW'(1);
         S_DATA: if (rx_cnt_q == BIT_END) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == LAST_BIT) rx_state_d = PAR_EN ? S_PARITY : S_STOP;
            else rx_bit_d = rx_bit_q + BW'(1);
         end else rx_cnt_d = rx_cnt_q + CW'(1);
         S_PARITY: if (rx_cnt_q == BIT_END) begin
            rx_state_d = S_STOP;
            rx_cnt_d   = '0;
            rx_par_d   = rx_s2_q;
         end else rx_cnt_d = rx_cnt_q + CW'(1);
         S_STOP: if (rx_cnt_q == BIT_END) begin
            rx_state_d = S_IDLE;
            if (!rx_s2_q) frame_err_d = 1'b1;
            if (par_bad)  parity_err_d = 1'b1;
            rx_push_d  = rx_s2_q && !par_bad;
         end else rx_cnt_d = rx_cnt_q + CW'(1);
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop        = rx_valid_q && bus.rx_ready;
      push_ok    = rx_push_q && ((rx_count_q != FULL_CNT) || pop);
      overrun_d  = (overrun_q & ~err_clr) | (rx_push_q && (rx_count_q == FULL_CNT) && !pop);
      mem_d      = mem_q;
      if (push_ok) mem_d[wr_ptr_q] = rx_shift_q;
      wr_ptr_d   = wr_ptr_q + AW'(push_ok);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      rx_count_d = rx_count_q;
      if (push_ok && !pop) rx_count_d = rx_count_q + NW'(1);
      else if (!push_ok && pop) rx_count_d = rx_count_q - NW'(1);
      rx_valid_d = (rx_count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_state_q   <= S_IDLE;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_shift_q   <= '0;
         tx_par_q     <= 1'b0;
         tx_q         <= 1'b1;
         tx_ready_q   <= 1'b1;
         tx_done_q    <= 1'b0;
         rx_state_q   <= S_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_par_q     <= 1'b0;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_push_q    <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         rx_valid_q   <= 1'b0;
         rx_count_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         for (int unsigned i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_shift_q   <= tx_shift_d;
         tx_par_q     <= tx_par_d;
         tx_q         <= tx_d;
         tx_ready_q   <= tx_ready_d;
         tx_done_q    <= tx_done_d;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_par_q     <= rx_par_d;
         rx_s1_q      <= rx;
         rx_s2_q      <= rx_s1_q;
         rx_prev_q    <= rx_s2_q;
         rx_push_q    <= rx_push_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         rx_valid_q   <= rx_valid_d;
         rx_count_q   <= rx_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         mem_q        <= mem_d;
      end
   end

   assign tx           = tx_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.tx_done  = tx_done_q;
   assign bus.rx_data  = mem_q[rd_ptr_q];
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_count = rx_count_q;
   assign parity_err   = parity_err_q;
   assign frame_err    = frame_err_q;
   assign overrun      = overrun_q;
endmodule

// File: tb/tb_uart_link.sv
// Bench for uart_link: an 8N1 instance (a) and an 8E1 instance (b) at 16 clocks per bit,
// with scoreboard queues of expected RX words.
module tb_uart_link;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   uart_link_if #(.DATA_BITS(8), .RX_FIFO_DEPTH(4)) bus_a ();
   uart_link_if #(.DATA_BITS(8), .RX_FIFO_DEPTH(4)) bus_b ();

   logic tx_a, rx_drv_a, perr_a, ferr_a, ovr_a, clr_a;
   logic tx_b, rx_b, rx_drv_b, perr_b, ferr_b, ovr_b, clr_b, loop_b;
   assign rx_b = loop_b ? tx_b : rx_drv_b;

   uart_link #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a), .tx(tx_a), .rx(rx_drv_a),
      .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .err_clr(clr_a));

   uart_link #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b), .tx(tx_b), .rx(rx_b),
      .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .err_clr(clr_b));

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic set_rx(input int which, input logic v);
      if (which == 0) rx_drv_a = v; else rx_drv_b = v;
   endtask

   task automatic drive_rx(input int which, input logic [7:0] d, input bit has_par,
                           input logic par, input logic stop);
      set_rx(which, 1'b0);
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         set_rx(which, d[i]);
         repeat (CPB) @(negedge clk);
      end
      if (has_par) begin
         set_rx(which, par);
         repeat (CPB) @(negedge clk);
      end
      set_rx(which, stop);
      repeat (CPB) @(negedge clk);
      set_rx(which, 1'b1);
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic drain(input int which, input string tag);
      logic       v;
      logic [7:0] d, e;
      int         left;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         v = (which == 0) ? bus_a.rx_valid : bus_b.rx_valid;
         d = (which == 0) ? bus_a.rx_data : bus_b.rx_data;
         if (!v) break;
         if (which == 0) bus_a.rx_ready = 1'b1; else bus_b.rx_ready = 1'b1;
         left = (which == 0) ? exp_a.size() : exp_b.size();
         n_checks++;
         if (left == 0) begin
            n_fail++;
            $display("FAIL %s_extra_word: got %h want none", tag, d);
         end else begin
            if (which == 0) e = exp_a.pop_front(); else e = exp_b.pop_front();
            if (d !== e) begin
               n_fail++;
               $display("FAIL %s_rx_data: got %h want %h", tag, d, e);
            end
         end
      end
      bus_a.rx_ready = 1'b0;
      bus_b.rx_ready = 1'b0;
      left = (which == 0) ? exp_a.size() : exp_b.size();
      n_checks++;
      if (left !== 0) begin
         n_fail++;
         $display("FAIL %s_missing_words: got %0d undelivered want 0", tag, left);
      end
      exp_a.delete();
      exp_b.delete();
   endtask

   task automatic test_reset;
      logic [17:0] obs;
      obs = {tx_a, bus_a.tx_ready, bus_a.tx_done, bus_a.rx_valid, bus_a.rx_count, bus_a.rx_data,
             perr_a, ferr_a, ovr_a};
      n_checks++;
      if (obs !== 18'b110_0_000_00000000_000) begin
         n_fail++;
         $display("FAIL reset_a: got %b want %b", obs, 18'b110_0_000_00000000_000);
      end
      obs = {tx_b, bus_b.tx_ready, bus_b.tx_done, bus_b.rx_valid, bus_b.rx_count, bus_b.rx_data,
             perr_b, ferr_b, ovr_b};
      n_checks++;
      if (obs !== 18'b110_0_000_00000000_000) begin
         n_fail++;
         $display("FAIL reset_b: got %b want %b", obs, 18'b110_0_000_00000000_000);
      end
   endtask

   task automatic test_tx_waveform;
      logic [9:0] frame;
      frame = {1'b1, 8'hA5, 1'b0};
      @(negedge clk);
      bus_a.tx_data  = 8'hA5;
      bus_a.tx_valid = 1'b1;
      for (int n = 1; n <= 162; n++) begin
         @(negedge clk);
         if (n == 1) bus_a.tx_valid = 1'b0;
         if (n == 50) begin bus_a.tx_data = 8'hFF; bus_a.tx_valid = 1'b1; end
         if (n == 51) bus_a.tx_valid = 1'b0;
         if (n <= 160) begin
            n_checks++;
            if (tx_a !== frame[(n-1)/16]) begin
               n_fail++;
               $display("FAIL tx_bit_cycle%0d: got %b want %b", n, tx_a, frame[(n-1)/16]);
            end
            n_checks++;
            if ({bus_a.tx_ready, bus_a.tx_done} !== 2'b00) begin
               n_fail++;
               $display("FAIL tx_busy_cycle%0d: got ready,done=%b want 00", n,
                        {bus_a.tx_ready, bus_a.tx_done});
            end
         end else if (n == 161) begin
            n_checks++;
            if ({tx_a, bus_a.tx_ready, bus_a.tx_done} !== 3'b111) begin
               n_fail++;
               $display("FAIL tx_done_161: got tx,ready,done=%b want 111",
                        {tx_a, bus_a.tx_ready, bus_a.tx_done});
            end
         end else begin
            n_checks++;
            if (bus_a.tx_done !== 1'b0) begin
               n_fail++;
               $display("FAIL tx_done_pulse_width: got %b want 0", bus_a.tx_done);
            end
         end
      end
   endtask

   task automatic test_loopback;
      logic [7:0] bl [3];
      bit         saw_hi;
      bit         got;
      bl = '{8'h00, 8'hFF, 8'h3C};
      rx_drv_b = 1'b1;
      loop_b   = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         bus_b.tx_data  = bl[i];
         bus_b.tx_valid = 1'b1;
         exp_b.push_back(bl[i]);
         saw_hi = 1'b0;
         for (int n = 1; n <= 177; n++) begin
            @(negedge clk);
            if (n == 1) bus_b.tx_valid = 1'b0;
            if (n <= 176 && bus_b.tx_ready !== 1'b0) saw_hi = 1'b1;
         end
         n_checks++;
         if (saw_hi !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_ready_low_frame%0d: got ready high in frame want low", i);
         end
         n_checks++;
         if ({bus_b.tx_ready, bus_b.tx_done} !== 2'b11) begin
            n_fail++;
            $display("FAIL loop_frame_end%0d: got ready,done=%b want 11", i,
                     {bus_b.tx_ready, bus_b.tx_done});
         end
      end
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         @(negedge clk);
         if (bus_b.rx_count == 3'd3) got = 1'b1;
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL loop_rx_count: got %0d want 3", bus_b.rx_count);
      end
      n_checks++;
      if ({perr_b, ferr_b, ovr_b} !== 3'b000) begin
         n_fail++;
         $display("FAIL loop_flags: got %b want 000", {perr_b, ferr_b, ovr_b});
      end
      drain(1, "loop");
      loop_b = 1'b0;
   endtask

   task automatic test_errors;
      logic [7:0] d;
      logic       good_par;
      d = 8'h55;
      good_par = ^d;
      drive_rx(1, d, 1'b1, ~good_par, 1'b1);
      n_checks++;
      if ({perr_b, ferr_b, bus_b.rx_count} !== 5'b10_000) begin
         n_fail++;
         $display("FAIL bad_parity: got perr,ferr,count=%b want 10000", {perr_b, ferr_b, bus_b.rx_count});
      end
      drive_rx(1, d, 1'b1, good_par, 1'b0);
      n_checks++;
      if ({perr_b, ferr_b, bus_b.rx_valid, bus_b.rx_count} !== 6'b11_0_000) begin
         n_fail++;
         $display("FAIL bad_stop: got perr,ferr,valid,count=%b want 110000",
                  {perr_b, ferr_b, bus_b.rx_valid, bus_b.rx_count});
      end
      clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      n_checks++;
      if ({perr_b, ferr_b, ovr_b} !== 3'b000) begin
         n_fail++;
         $display("FAIL err_clr: got %b want 000", {perr_b, ferr_b, ovr_b});
      end
   endtask

   task automatic test_glitch;
      rx_drv_a = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv_a = 1'b1;
      repeat (48) @(negedge clk);
      n_checks++;
      if ({bus_a.rx_valid, bus_a.rx_count, perr_a, ferr_a, ovr_a} !== 7'b0_000_000) begin
         n_fail++;
         $display("FAIL glitch: got valid,count,flags=%b want 0000000",
                  {bus_a.rx_valid, bus_a.rx_count, perr_a, ferr_a, ovr_a});
      end
      exp_a.push_back(8'h3A);
      drive_rx(0, 8'h3A, 1'b0, 1'b0, 1'b1);
      drain(0, "after_glitch");
   endtask

   task automatic test_overrun;
      logic [7:0] w [6];
      logic [7:0] e;
      bit         seen;
      w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_a.push_back(w[i]);
         drive_rx(0, w[i], 1'b0, 1'b0, 1'b1);
      end
      n_checks++;
      if ({bus_a.rx_valid, bus_a.rx_count, ovr_a, bus_a.rx_data} !== {1'b1, 3'd4, 1'b1, w[0]}) begin
         n_fail++;
         $display("FAIL overrun_full: got valid,count,ovr,head=%b,%0d,%b,%h want 1,4,1,%h",
                  bus_a.rx_valid, bus_a.rx_count, ovr_a, bus_a.rx_data, w[0]);
      end
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      n_checks++;
      if (ovr_a !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clr: got %b want 0", ovr_a);
      end
      exp_a.push_back(w[5]);
      fork
         drive_rx(0, w[5], 1'b0, 1'b0, 1'b1);
         begin
            seen = 1'b0;
            for (int c = 0; c < 300 && !seen; c++) begin
               @(negedge clk);
               if (dut_a.rx_push_q === 1'b1) seen = 1'b1;
            end
            n_checks++;
            if (!seen) begin
               n_fail++;
               $display("FAIL push_full_timeout: got no push want push");
            end else begin
               bus_a.rx_ready = 1'b1;
               e = exp_a.pop_front();
               n_checks++;
               if (bus_a.rx_data !== e) begin
                  n_fail++;
                  $display("FAIL push_pop_head: got %h want %h", bus_a.rx_data, e);
               end
               @(negedge clk);
               bus_a.rx_ready = 1'b0;
               n_checks++;
               if ({bus_a.rx_count, ovr_a} !== {3'd4, 1'b0}) begin
                  n_fail++;
                  $display("FAIL push_pop_full: got count,ovr=%0d,%b want 4,0", bus_a.rx_count, ovr_a);
               end
            end
         end
      join
      drain(0, "overrun");
   endtask

   task automatic test_reset_mid;
      logic [17:0] obs;
      drive_rx(0, 8'h5A, 1'b0, 1'b0, 1'b0);
      drive_rx(0, 8'h77, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      fork
         drive_rx(0, 8'hC3, 1'b0, 1'b0, 1'b1);
         begin
            bus_a.tx_data  = 8'h0F;
            bus_a.tx_valid = 1'b1;
            @(negedge clk);
            bus_a.tx_valid = 1'b0;
            repeat (88) @(negedge clk);
            n_checks++;
            if ({tx_a, bus_a.tx_ready, ferr_a, bus_a.rx_count} !== {1'b0, 1'b0, 1'b1, 3'd1}) begin
               n_fail++;
               $display("FAIL pre_reset: got tx,ready,ferr,count=%b,%b,%b,%0d want 0,0,1,1",
                        tx_a, bus_a.tx_ready, ferr_a, bus_a.rx_count);
            end
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            obs = {tx_a, bus_a.tx_ready, bus_a.tx_done, bus_a.rx_valid, bus_a.rx_count,
                   bus_a.rx_data, perr_a, ferr_a, ovr_a};
            n_checks++;
            if (obs !== 18'b110_0_000_00000000_000) begin
               n_fail++;
               $display("FAIL reset_mid: got %b want %b", obs, 18'b110_0_000_00000000_000);
            end
         end
      join
      exp_a.delete();
   endtask

   initial begin
      bus_a.tx_data = '0; bus_a.tx_valid = 1'b0; bus_a.rx_ready = 1'b0;
      bus_b.tx_data = '0; bus_b.tx_valid = 1'b0; bus_b.rx_ready = 1'b0;
      rx_drv_a = 1'b1; rx_drv_b = 1'b1; loop_b = 1'b0;
      clr_a = 1'b0; clr_b = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      test_tx_waveform;
      test_loopback;
      test_errors;
      test_glitch;
      test_overrun;
      test_reset_mid;
      repeat (20) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
